// File: rtl/dw_lsd_denorm_seq.sv
// Sequential leading-sign denormalizer. Restores norm_a >>> enc by shifting one bit per clock.
// Latency: with k = min(enc, a_width-1), out_valid rises k+1 cycles after the accept edge.
// Backpressure: dec_a/enc_err are held while out_valid && !out_ready; in_ready is low until the block returns to IDLE.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (norm_a, enc)
//   out_valid/out_ready result handshake (dec_a, enc_err)
//   busy                transaction in flight (state != IDLE)
module dw_lsd_denorm_seq #(
  parameter int a_width    = 8,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [a_width-1:0]    norm_a,
  input  logic [addr_width-1:0] enc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [a_width-1:0]    dec_a,
  output logic                  enc_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest meaningful shift; anything beyond it only replicates the sign bit.
  localparam logic [addr_width-1:0] max_cnt = addr_width'(a_width - 1);

  state_t                state;
  logic [a_width-1:0]    shift_reg;
  logic [addr_width-1:0] count;
  logic                  err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= norm_a;
            if (enc > max_cnt) begin
              count   <= max_cnt;
              err_reg <= 1'b1;
            end else begin
              count   <= enc;
              err_reg <= 1'b0;
            end
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (count == '0) begin
            state <= DONE;
          end else begin
            // Arithmetic right shift by one: replicate the sign bit.
            shift_reg <= {shift_reg[a_width-1], shift_reg[a_width-1:1]};
            count     <= count - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dec_a     = shift_reg;
  assign enc_err   = err_reg;

endmodule
